ctrl_fsm: RTL

- Multi-cycle control sequencer for the RV32I core.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath select and strobe.
- Drives the immediate generator's imm_sel, the ALU operand muxes, PC update, register-file write and data-memory handshake.
- Sits between the instruction register and the shared datapath; one instruction in flight at a time.

---
 rtl/riscv_pkg.sv | 65 ++++++
 rtl/ctrl_decode.sv | 29 ++
 rtl/ctrl_fsm.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, datapath select encodings,
// sequencer state codes and the opcode-class bundle produced by the decoder.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Must match the immediate generator's decode of imm_sel.
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic opimm;
    logic op;
  } insn_class_t;

  function automatic logic [2:0] imm_sel_of(input insn_class_t c);
    logic [2:0] sel;
    if (c.lui || c.auipc) begin
      sel = IMM_U;
    end else if (c.jal) begin
      sel = IMM_J;
    end else if (c.jalr || c.load || c.opimm) begin
      sel = IMM_I;
    end else if (c.branch) begin
      sel = IMM_B;
    end else if (c.store) begin
      sel = IMM_S;
    end else begin
      sel = IMM_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: maps insn[6:0] to a one-hot class bundle and flags
// any opcode the core does not implement.
module ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  output insn_class_t cls,
  output logic        illegal
);

  // One-hot class lookup; unknown opcodes leave every class bit clear.
  always_comb begin
    cls     = '{default: 1'b0};
    illegal = 1'b0;
    case (opcode)
      OPC_LUI:    cls.lui    = 1'b1;
      OPC_AUIPC:  cls.auipc  = 1'b1;
      OPC_JAL:    cls.jal    = 1'b1;
      OPC_JALR:   cls.jalr   = 1'b1;
      OPC_BRANCH: cls.branch = 1'b1;
      OPC_LOAD:   cls.load   = 1'b1;
      OPC_STORE:  cls.store  = 1'b1;
      OPC_OPIMM:  cls.opimm  = 1'b1;
      OPC_OP:     cls.op     = 1'b1;
      default:    illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: one instruction in flight, walked
// through FETCH/DECODE/EXEC/MEM/WB, with a sticky trap on unknown opcodes.
module ctrl_fsm
  import riscv_pkg::*;
#(
  parameter bit RESET_TRAP_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] insn,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic [2:0]  imm_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        retire,
  output logic        illegal
);

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic        illegal_r;
  logic        set_illegal_s;
  logic        bad_op_s;
  insn_class_t cls_s;

  ctrl_decode u_decode (
    .opcode  (insn[6:0]),
    .cls     (cls_s),
    .illegal (bad_op_s)
  );

  assign illegal = illegal_r;

  // Next state and all datapath controls; reset forces every control low.
  always_comb begin
    state_nxt_s   = state_r;
    set_illegal_s = 1'b0;
    imem_req      = 1'b0;
    ir_we         = 1'b0;
    imm_sel       = IMM_NONE;
    alu_src_a     = 1'b0;
    alu_src_b     = 1'b0;
    dmem_re       = 1'b0;
    dmem_we       = 1'b0;
    reg_we        = 1'b0;
    wb_sel        = WB_ALU;
    pc_we         = 1'b0;
    pc_sel        = 1'b0;
    retire        = 1'b0;
    if (reset) begin
      state_nxt_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we       = 1'b1;
            state_nxt_s = ST_DECODE;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end
        ST_DECODE: begin
          imm_sel = imm_sel_of(cls_s);
          if (bad_op_s) begin
            set_illegal_s = 1'b1;
            state_nxt_s   = ST_TRAP;
          end else begin
            state_nxt_s = ST_EXEC;
          end
        end
        ST_EXEC: begin
          imm_sel   = imm_sel_of(cls_s);
          alu_src_a = cls_s.auipc | cls_s.jal | cls_s.branch;
          alu_src_b = ~cls_s.op;
          if (cls_s.branch) begin
            pc_we       = 1'b1;
            pc_sel      = br_taken;
            retire      = 1'b1;
            state_nxt_s = ST_FETCH;
          end else if (cls_s.load || cls_s.store) begin
            state_nxt_s = ST_MEM;
          end else begin
            state_nxt_s = ST_WB;
          end
        end
        ST_MEM: begin
          imm_sel = imm_sel_of(cls_s);
          dmem_re = cls_s.load;
          dmem_we = cls_s.store;
          if (!dmem_ready) begin
            state_nxt_s = ST_MEM;
          end else if (cls_s.store) begin
            pc_we       = 1'b1;
            retire      = 1'b1;
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_WB;
          end
        end
        ST_WB: begin
          imm_sel     = imm_sel_of(cls_s);
          reg_we      = 1'b1;
          pc_we       = 1'b1;
          retire      = 1'b1;
          pc_sel      = cls_s.jal | cls_s.jalr;
          state_nxt_s = ST_FETCH;
          if (cls_s.load) begin
            wb_sel = WB_MEM;
          end else if (cls_s.jal || cls_s.jalr) begin
            wb_sel = WB_PC4;
          end else if (cls_s.lui) begin
            wb_sel = WB_IMM;
          end else begin
            wb_sel = WB_ALU;
          end
        end
        ST_TRAP: begin
          state_nxt_s = ST_TRAP;
        end
        default: begin
          state_nxt_s = ST_FETCH;
        end
      endcase
    end
  end

  // State register and sticky illegal flag; debug builds keep the flag across reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH;
      if (RESET_TRAP_CLEAR) begin
        illegal_r <= 1'b0;
      end else begin
        illegal_r <= illegal_r;
      end
    end else begin
      state_r   <= state_nxt_s;
      illegal_r <= illegal_r | set_illegal_s;
    end
  end

endmodule
